prio_result_arbiter: RTL

- Sits directly after the final priority solver, which emits up to two resolved results per cycle (lane 1, lane 2), each a rule ID plus data-valid and action-valid flags.
- Buffers each lane in its own small FIFO and drains both onto a single valid/ready output port with round-robin arbitration; this is the output stage towards the action/host interface.
- The classifier pipeline cannot stall, so results arriving at a full FIFO are dropped and counted.

---
 rtl/prio_pkg.sv | 25 ++
 rtl/result_lane_fifo.sv | 62 ++++++
 rtl/prio_result_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/prio_pkg.sv
// Shared widths, lane encoding and round-robin helper for the result arbiter.
package prio_pkg;

    localparam int unsigned RULE_ID_W = 14;
    localparam int unsigned ENTRY_W   = RULE_ID_W + 1;

    typedef enum logic {
        LANE1 = 1'b0,
        LANE2 = 1'b1
    } lane_e;

    // Lane choice given which FIFOs hold data and who was served last.
    function automatic lane_e rr_pick(input logic ne1, input logic ne2, input lane_e last);
        lane_e pick;
        if (ne1 && ne2) begin
            pick = (last == LANE1) ? LANE2 : LANE1;
        end else if (ne2) begin
            pick = LANE2;
        end else begin
            pick = LANE1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/result_lane_fifo.sv
// Per-lane result FIFO: register array, registered count, natural pointer wrap.
module result_lane_fifo
    import prio_pkg::*;
#(
    parameter int unsigned WIDTH = ENTRY_W,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prio_result_arbiter.sv
// Two-lane result buffer with round-robin drain onto one valid/ready port.
module prio_result_arbiter
    import prio_pkg::*;
#(
    parameter int unsigned RULE_ID    = RULE_ID_W,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PTR_W      = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               RSTn,
    input  logic [RULE_ID-1:0] rule_id_in1,
    input  logic [RULE_ID-1:0] rule_id_in2,
    input  logic               data_valid_in1,
    input  logic               data_valid_in2,
    input  logic               action_valid_in1,
    input  logic               action_valid_in2,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [RULE_ID-1:0] out_rule_id,
    output logic               out_act_valid,
    output logic               out_lane,
    output logic               fifo_full1,
    output logic               fifo_full2,
    output logic [CNT_W-1:0]   drop_cnt1,
    output logic [CNT_W-1:0]   drop_cnt2,
    input  logic               drop_clr
);

    localparam int unsigned ENTRY_BITS = RULE_ID + 1;

    logic [ENTRY_BITS-1:0] head1;
    logic [ENTRY_BITS-1:0] head2;
    logic [ENTRY_BITS-1:0] gnt_entry;
    logic                  full1;
    logic                  full2;
    logic                  empty1;
    logic                  empty2;
    logic                  push1;
    logic                  push2;
    logic                  drop1;
    logic                  drop2;
    logic                  pop1;
    logic                  pop2;
    logic                  load_en;
    logic                  gnt_vld;
    lane_e                 gnt_lane;
    lane_e                 last_grant;

    // Full is the pre-edge registered state, so a same-cycle pop never frees a slot for a push.
    assign push1 = data_valid_in1 && !full1;
    assign push2 = data_valid_in2 && !full2;
    assign drop1 = data_valid_in1 && full1;
    assign drop2 = data_valid_in2 && full2;

    assign fifo_full1 = full1;
    assign fifo_full2 = full2;

    assign load_en = !out_valid || out_ready;
    assign pop1    = gnt_vld && (gnt_lane == LANE1);
    assign pop2    = gnt_vld && (gnt_lane == LANE2);

    result_lane_fifo #(
        .WIDTH (ENTRY_BITS),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo1 (
        .clk   (clk),
        .RSTn  (RSTn),
        .push  (push1),
        .pop   (pop1),
        .din   ({action_valid_in1, rule_id_in1}),
        .head  (head1),
        .full  (full1),
        .empty (empty1)
    );

    result_lane_fifo #(
        .WIDTH (ENTRY_BITS),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo2 (
        .clk   (clk),
        .RSTn  (RSTn),
        .push  (push2),
        .pop   (pop2),
        .din   ({action_valid_in2, rule_id_in2}),
        .head  (head2),
        .full  (full2),
        .empty (empty2)
    );

    // Round-robin grant selection and head mux.
    always_comb begin
        gnt_lane  = rr_pick(!empty1, !empty2, last_grant);
        gnt_vld   = load_en && (!empty1 || !empty2);
        gnt_entry = (gnt_lane == LANE2) ? head2 : head1;
    end

    // Output register: load on a free or accepted slot, otherwise hold.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            out_valid     <= 1'b0;
            out_rule_id   <= '0;
            out_act_valid <= 1'b0;
            out_lane      <= 1'b0;
            last_grant    <= LANE2;
        end else if (load_en) begin
            if (gnt_vld) begin
                out_valid     <= 1'b1;
                out_rule_id   <= gnt_entry[RULE_ID-1:0];
                out_act_valid <= gnt_entry[RULE_ID];
                out_lane      <= gnt_lane;
                last_grant    <= gnt_lane;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Lane-1 saturating drop counter; a clear coinciding with a drop leaves 1.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            drop_cnt1 <= '0;
        end else if (drop_clr) begin
            drop_cnt1 <= drop1 ? CNT_W'(1) : '0;
        end else if (drop1 && (drop_cnt1 != '1)) begin
            drop_cnt1 <= drop_cnt1 + 1'b1;
        end
    end

    // Lane-2 saturating drop counter; a clear coinciding with a drop leaves 1.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            drop_cnt2 <= '0;
        end else if (drop_clr) begin
            drop_cnt2 <= drop2 ? CNT_W'(1) : '0;
        end else if (drop2 && (drop_cnt2 != '1)) begin
            drop_cnt2 <= drop_cnt2 + 1'b1;
        end
    end

endmodule
